// File: rtl/delay_tap_capture_rx.sv
// Launches an edge into an external tapped delay line, captures the taps after a settle time,
// and reports the average, min and max thermometer tap count over 2^AVG_LOG2 samples.
module delay_tap_capture_rx #(
  parameter int NTAPS    = 6,
  parameter int CNT_W    = 3,
  parameter int SETTLE   = 2,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NTAPS-1:0] taps,
  output logic             launch,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] result_tap,
  output logic [CNT_W-1:0] result_min,
  output logic [CNT_W-1:0] result_max,
  output logic             err_bubble
);

  localparam int SUM_W = CNT_W + AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int NSAMP = 1 << AVG_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CAPTURE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t             state_q;
  logic               launch_q;
  logic [SET_W-1:0]   set_cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NTAPS-1:0]   norm_q;
  logic [SUM_W-1:0]   sum_q;
  logic [CNT_W-1:0]   min_q;
  logic [CNT_W-1:0]   max_q;
  logic               err_q;
  logic               valid_q;
  logic [CNT_W-1:0]   tap_q;
  logic [CNT_W-1:0]   rmin_q;
  logic [CNT_W-1:0]   rmax_q;

  logic [CNT_W-1:0]   cnt_d;
  logic               bubble_d;
  logic               gap;
  logic [SUM_W-1:0]   sum_d;
  logic [CNT_W-1:0]   min_d;
  logic [CNT_W-1:0]   max_d;
  logic               last_sample;

  // Leading-ones count; any 1 found after the first 0 marks a bubble.
  always_comb begin
    cnt_d    = '0;
    bubble_d = 1'b0;
    gap      = 1'b0;
    for (int i = 0; i < NTAPS; i++) begin
      if (!norm_q[i]) begin
        gap = 1'b1;
      end else if (gap) begin
        bubble_d = 1'b1;
      end else begin
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
  end

  assign sum_d       = sum_q + SUM_W'(cnt_d);
  assign min_d       = (cnt_d < min_q) ? cnt_d : min_q;
  assign max_d       = (cnt_d > max_q) ? cnt_d : max_q;
  assign last_sample = (idx_q == IDX_W'(NSAMP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      launch_q  <= 1'b0;
      set_cnt_q <= '0;
      idx_q     <= '0;
      norm_q    <= '0;
      sum_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      tap_q     <= '0;
      rmin_q    <= '0;
      rmax_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LAUNCH;
            sum_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            min_q   <= '1;
            max_q   <= '0;
          end
        end
        S_LAUNCH: begin
          launch_q  <= ~launch_q;
          set_cnt_q <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (set_cnt_q == SET_W'(SETTLE - 1)) begin
            state_q <= S_CAPTURE;
          end else begin
            set_cnt_q <= set_cnt_q + SET_W'(1);
          end
        end
        S_CAPTURE: begin
          // Normalise so a 1 always means the launched edge reached that tap.
          norm_q  <= launch_q ? taps : ~taps;
          state_q <= S_ACCUM;
        end
        S_ACCUM: begin
          sum_q <= sum_d;
          min_q <= min_d;
          max_q <= max_d;
          if (bubble_d) begin
            err_q <= 1'b1;
          end
          if (last_sample) begin
            state_q <= S_DONE;
            valid_q <= 1'b1;
            tap_q   <= CNT_W'(sum_d >> AVG_LOG2);
            rmin_q  <= min_d;
            rmax_q  <= max_d;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            state_q <= S_LAUNCH;
          end
        end
        S_DONE: begin
          if (result_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign launch       = launch_q;
  assign busy         = (state_q != S_IDLE);
  assign result_valid = valid_q;
  assign result_tap   = tap_q;
  assign result_min   = rmin_q;
  assign result_max   = rmax_q;
  assign err_bubble   = err_q;

endmodule

// File: tb/tb_delay_tap_capture_rx.sv
// Randomised and directed bench for delay_tap_capture_rx against a cycle-count reference model.
module tb_delay_tap_capture_rx;

  localparam int NTAPS    = 6;
  localparam int CNT_W    = 3;
  localparam int SETTLE   = 2;
  localparam int AVG_LOG2 = 2;
  localparam int NS       = 1 << AVG_LOG2;
  localparam int PER      = SETTLE + 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start = 1'b0;
  logic             result_ready = 1'b0;
  logic [NTAPS-1:0] taps;
  logic             launch, busy, result_valid, err_bubble;
  logic [CNT_W-1:0] result_tap, result_min, result_max;

  logic [NTAPS-1:0] cur_norm = '0;
  logic [NTAPS-1:0] pats [NS];

  int n_cmp = 0;
  int n_bad = 0;

  delay_tap_capture_rx #(
    .NTAPS(NTAPS), .CNT_W(CNT_W), .SETTLE(SETTLE), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .taps(taps), .launch(launch),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .result_tap(result_tap), .result_min(result_min), .result_max(result_max),
    .err_bubble(err_bubble)
  );

  always #5 clk = ~clk;

  // The external delay line: the current sample's normalised pattern in the launch polarity.
  always_comb taps = launch ? cur_norm : ~cur_norm;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lead_ones(input logic [NTAPS-1:0] p);
    int c = 0;
    while (c < NTAPS && p[c]) c++;
    return c;
  endfunction

  // Reference model: elapsed edges since the accepted start decide everything.
  bit m_busy = 0, m_valid = 0, m_launch = 0, m_err = 0;
  int m_edges = 0, m_tap = 0, m_min = 0, m_max = 0;
  int cyc = 0, start_cyc = 0;
  int p_tap = 0, p_min = 0, p_max = 0;
  bit p_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_launch = 0; m_err = 0;
      m_tap = 0; m_min = 0; m_max = 0; m_edges = 0;
    end else begin
      cyc++;
      if (!m_busy) begin
        if (start) begin
          int s, mn, mx, c;
          bit e;
          s = 0; mn = 1000; mx = -1; e = 0;
          for (int k = 0; k < NS; k++) begin
            c  = lead_ones(pats[k]);
            s += c;
            if (c < mn) mn = c;
            if (c > mx) mx = c;
            if ((pats[k] >> c) != 0) e = 1;
          end
          p_tap = s / NS; p_min = mn; p_max = mx; p_err = e;
          m_busy = 1; m_edges = 0; start_cyc = cyc;
        end
      end else if (!m_valid) begin
        m_edges++;
        if ((m_edges - 1) % PER == 0) m_launch = !m_launch;
        if (m_edges == NS * PER) begin
          m_valid = 1;
          m_tap = p_tap; m_min = p_min; m_max = p_max; m_err = p_err;
        end
      end else if (result_ready) begin
        m_busy = 0; m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("launch", launch, m_launch);
      chk("busy", busy, m_busy);
      chk("result_valid", result_valid, m_valid);
      chk("result_tap", result_tap, m_tap);
      chk("result_min", result_min, m_min);
      chk("result_max", result_max, m_max);
      if (!m_busy || m_valid) chk("err_bubble", err_bubble, m_err);
    end
  end

  function automatic logic [NTAPS-1:0] rand_pat();
    int c;
    logic [NTAPS-1:0] p;
    c = $urandom_range(0, NTAPS);
    p = NTAPS'((1 << c) - 1);
    if (c < NTAPS - 1 && $urandom_range(0, 3) == 0) p[$urandom_range(c + 1, NTAPS - 1)] = 1'b1;
    return p;
  endfunction

  // Called and returns on a falling edge with the DUT idle.
  task automatic do_run(input logic [NTAPS-1:0] a, b, c, d,
                        input int e_tap, e_min, e_max, e_err,
                        input bit hold, input bit noise);
    int tog;
    bit ok;
    logic pl;
    tog = 0;
    pats[0] = a; pats[1] = b; pats[2] = c; pats[3] = d;
    cur_norm = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < NS; k++) begin
      ok = 0;
      pl = launch;
      for (int i = 0; i < 3 * PER && !ok; i++) begin
        @(negedge clk);
        if (noise) start = 1'($urandom_range(0, 1));
        if (launch != pl) ok = 1;
      end
      if (ok) begin
        tog++;
        cur_norm = pats[k];
      end
    end
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 4 * PER && !ok; i++) begin
      if (result_valid) ok = 1;
      else @(negedge clk);
    end
    chk("valid_seen", ok, 1);
    chk("valid_latency", cyc - start_cyc, NS * PER);
    chk("launch_toggles", tog, NS);
    if (e_tap >= 0) begin
      chk("lit_tap", result_tap, e_tap);
      chk("lit_min", result_min, e_min);
      chk("lit_max", result_max, e_max);
      chk("lit_err", err_bubble, e_err);
    end
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        start = (i == 3);
        @(negedge clk);
        chk("hold_valid", result_valid, 1);
        chk("hold_busy", busy, 1);
      end
      start = 1'b0;
      if (e_tap >= 0) chk("hold_tap", result_tap, e_tap);
    end else begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("post_accept_valid", result_valid, 0);
    chk("post_accept_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_launch", launch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_tap", result_tap, 0);
    chk("rst_min", result_min, 0);
    chk("rst_max", result_max, 0);
    chk("rst_err", err_bubble, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort a run in WAIT with an asynchronous reset.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_launch", launch, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", result_valid, 0);
    chk("midrst_err", err_bubble, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_run(6'b000111, 6'b000111, 6'b000111, 6'b000111, 3, 3, 3, 0, 0, 0);
    do_run(6'b000001, 6'b000011, 6'b001111, 6'b011111, 3, 1, 5, 0, 0, 0);
    do_run(6'b000000, 6'b000000, 6'b000000, 6'b000000, 0, 0, 0, 0, 0, 0);
    do_run(6'b111111, 6'b111111, 6'b111111, 6'b111111, 6, 6, 6, 0, 0, 0);
    do_run(6'b000011, 6'b000101, 6'b000011, 6'b000011, 1, 1, 2, 1, 0, 0);
    do_run(6'b000011, 6'b000011, 6'b000011, 6'b000011, 2, 2, 2, 0, 0, 0);
    do_run(6'b001111, 6'b000111, 6'b011111, 6'b000011, 3, 2, 5, 0, 1, 0);
    do_run(6'b000001, 6'b000001, 6'b000011, 6'b000001, 1, 1, 2, 0, 0, 0);

    for (int r = 0; r < 12; r++) begin
      do_run(rand_pat(), rand_pat(), rand_pat(), rand_pat(), -1, 0, 0, 0,
             1'($urandom_range(0, 3) == 0), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
